// File: rtl/mesi_isc_agent_pkg.sv
// Shared types and bus encodings for the MESI ISC CPU-side coherence agent.
// Command codes follow the mesi_isc_define numbering used by the ISC.
package mesi_isc_agent_pkg;

  localparam logic [2:0] MBUS_CMD_NOP      = 3'd0;
  localparam logic [2:0] MBUS_CMD_WR       = 3'd1;
  localparam logic [2:0] MBUS_CMD_RD       = 3'd2;
  localparam logic [2:0] MBUS_CMD_WR_BROAD = 3'd3;
  localparam logic [2:0] MBUS_CMD_RD_BROAD = 3'd4;

  localparam logic [2:0] CBUS_CMD_NOP      = 3'd0;
  localparam logic [2:0] CBUS_CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CBUS_CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CBUS_CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CBUS_CMD_EN_RD    = 3'd4;

  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_state_t;
  typedef enum logic [2:0] {R_IDLE, R_WB, R_BROAD, R_WAIT_EN, R_DONE} req_state_t;
  typedef enum logic [1:0] {C_IDLE, C_WB, C_ACK, C_WAIT_NOP} cbus_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mesi_isc_agent_tag_array.sv
// Direct-mapped MESI state + tag store: two combinational read ports
// (request side, snoop side) and a single write port.
module mesi_isc_agent_tag_array
  import mesi_isc_agent_pkg::*;
#(
  parameter int LINES_LOG2 = 2,
  parameter int TAG_W      = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINES_LOG2-1:0] ra_idx,
  output mesi_state_t           ra_state,
  output logic [TAG_W-1:0]      ra_tag,
  input  logic [LINES_LOG2-1:0] rb_idx,
  output mesi_state_t           rb_state,
  output logic [TAG_W-1:0]      rb_tag,
  input  logic                  we,
  input  logic [LINES_LOG2-1:0] w_idx,
  input  mesi_state_t           w_state,
  input  logic [TAG_W-1:0]      w_tag
);
  localparam int LINES = 1 << LINES_LOG2;

  mesi_state_t      st [LINES];
  logic [TAG_W-1:0] tg [LINES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) begin
        st[i] <= MESI_I;
        tg[i] <= '0;
      end
    end else if (we) begin
      st[w_idx] <= w_state;
      tg[w_idx] <= w_tag;
    end
  end

  assign ra_state = st[ra_idx];
  assign ra_tag   = tg[ra_idx];
  assign rb_state = st[rb_idx];
  assign rb_tag   = tg[rb_idx];

endmodule

// File: rtl/mesi_isc_cpu_agent.sv
// Per-CPU MESI coherence agent: request FSM drives mbus, cbus FSM services snoops/enables.
// Define MESI_ISC_AGENT_CNT_EN to add saturating hit/miss/snoop counters.
module mesi_isc_cpu_agent
  import mesi_isc_agent_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int LINES_LOG2     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_i,
  input  logic                      cpu_wr_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
  output logic                      cpu_busy_o,
  output logic                      cpu_done_o,
  output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
  input  logic                      mbus_ack_i,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o
`ifdef MESI_ISC_AGENT_CNT_EN
  ,
  output logic [15:0]               hit_cnt_o,
  output logic [15:0]               miss_cnt_o,
  output logic [15:0]               snoop_cnt_o
`endif
);
  localparam int TAG_W = ADDR_WIDTH - LINES_LOG2;

  localparam logic [MBUS_CMD_WIDTH-1:0] MB_NOP = MBUS_CMD_WIDTH'(MBUS_CMD_NOP);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR  = MBUS_CMD_WIDTH'(MBUS_CMD_WR);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WRB = MBUS_CMD_WIDTH'(MBUS_CMD_WR_BROAD);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_RDB = MBUS_CMD_WIDTH'(MBUS_CMD_RD_BROAD);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_NOP = CBUS_CMD_WIDTH'(CBUS_CMD_NOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_WRS = CBUS_CMD_WIDTH'(CBUS_CMD_WR_SNOOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_RDS = CBUS_CMD_WIDTH'(CBUS_CMD_RD_SNOOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_ENW = CBUS_CMD_WIDTH'(CBUS_CMD_EN_WR);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_ENR = CBUS_CMD_WIDTH'(CBUS_CMD_EN_RD);

  req_state_t              r_state;
  cbus_state_t             c_state;
  logic [ADDR_WIDTH-1:0]   r_addr, v_addr, c_addr;
  logic                    r_wr, c_rd, c_owns;

  mesi_state_t             ra_state, rb_state, w_state;
  logic [TAG_W-1:0]        ra_tag, rb_tag, w_tag;
  logic [LINES_LOG2-1:0]   w_idx;
  logic                    we;

  logic ra_hit, rb_hit, cb_idle, accept, c_decode, is_wrs, is_rds, is_en;
  logic snoop_wb, en_fill, mb_busy, ack_c, ack_r;

  mesi_isc_agent_tag_array #(.LINES_LOG2(LINES_LOG2), .TAG_W(TAG_W)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .ra_idx  (cpu_addr_i[LINES_LOG2-1:0]),
    .ra_state(ra_state),
    .ra_tag  (ra_tag),
    .rb_idx  (cbus_addr_i[LINES_LOG2-1:0]),
    .rb_state(rb_state),
    .rb_tag  (rb_tag),
    .we      (we),
    .w_idx   (w_idx),
    .w_state (w_state),
    .w_tag   (w_tag)
  );

  assign ra_hit   = (ra_state != MESI_I) && (ra_tag == cpu_addr_i[ADDR_WIDTH-1:LINES_LOG2]);
  assign rb_hit   = (rb_state != MESI_I) && (rb_tag == cbus_addr_i[ADDR_WIDTH-1:LINES_LOG2]);
  assign cb_idle  = (cbus_cmd_i == CB_NOP);
  assign is_wrs   = (cbus_cmd_i == CB_WRS);
  assign is_rds   = (cbus_cmd_i == CB_RDS);
  assign is_en    = (cbus_cmd_i == CB_ENW) || (cbus_cmd_i == CB_ENR);
  // Accepting only while the snoop side is quiet keeps the two FSMs off the write port together.
  assign accept   = (r_state == R_IDLE) && cpu_req_i && (c_state == C_IDLE) && cb_idle;
  assign c_decode = (c_state == C_IDLE) && !cb_idle;
  assign snoop_wb = (is_wrs || is_rds) && rb_hit && (rb_state == MESI_M);
  assign en_fill  = c_decode && is_en && (r_state == R_WAIT_EN) && (cbus_addr_i == r_addr);
  assign mb_busy  = (mbus_cmd_o != MB_NOP);
  assign ack_c    = mb_busy && mbus_ack_i && c_owns;
  assign ack_r    = mb_busy && mbus_ack_i && !c_owns;

  assign cpu_busy_o = (r_state != R_IDLE) || (cpu_req_i && !((c_state == C_IDLE) && cb_idle));

  always_comb begin
    we      = 1'b0;
    w_idx   = cpu_addr_i[LINES_LOG2-1:0];
    w_tag   = cpu_addr_i[ADDR_WIDTH-1:LINES_LOG2];
    w_state = MESI_I;
    if (accept && ra_hit && cpu_wr_i && (ra_state == MESI_E)) begin
      we      = 1'b1;
      w_state = MESI_M;
    end else if (en_fill) begin
      we      = 1'b1;
      w_idx   = r_addr[LINES_LOG2-1:0];
      w_tag   = r_addr[ADDR_WIDTH-1:LINES_LOG2];
      w_state = r_wr ? MESI_M : MESI_S;
    end else if ((c_state == C_WB) && ack_c) begin
      we      = 1'b1;
      w_idx   = c_addr[LINES_LOG2-1:0];
      w_tag   = c_addr[ADDR_WIDTH-1:LINES_LOG2];
      w_state = c_rd ? MESI_S : MESI_I;
    end else if (c_decode && rb_hit && !snoop_wb) begin
      w_idx = cbus_addr_i[LINES_LOG2-1:0];
      w_tag = cbus_addr_i[ADDR_WIDTH-1:LINES_LOG2];
      if (is_wrs) begin
        we      = 1'b1;
        w_state = MESI_I;
      end else if (is_rds && (rb_state == MESI_E)) begin
        we      = 1'b1;
        w_state = MESI_S;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= R_IDLE;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      v_addr     <= '0;
      cpu_done_o <= 1'b0;
    end else begin
      cpu_done_o <= 1'b0;
      case (r_state)
        R_IDLE: if (accept) begin
          r_addr <= cpu_addr_i;
          r_wr   <= cpu_wr_i;
          v_addr <= {ra_tag, cpu_addr_i[LINES_LOG2-1:0]};
          if (ra_hit && (!cpu_wr_i || ra_state == MESI_E || ra_state == MESI_M))
            cpu_done_o <= 1'b1;
          else if (!ra_hit && ra_state == MESI_M)
            r_state <= R_WB;
          else
            r_state <= R_BROAD;
        end
        R_WB:      if (ack_r) r_state <= R_BROAD;
        R_BROAD:   if (ack_r) r_state <= R_WAIT_EN;
        R_WAIT_EN: if (en_fill) begin
          r_state    <= R_DONE;
          cpu_done_o <= 1'b1;
        end
        R_DONE:    r_state <= R_IDLE;
        default:   r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_state    <= C_IDLE;
      c_addr     <= '0;
      c_rd       <= 1'b0;
      cbus_ack_o <= 1'b0;
    end else begin
      cbus_ack_o <= 1'b0;
      case (c_state)
        C_IDLE: if (!cb_idle) begin
          c_addr <= cbus_addr_i;
          c_rd   <= is_rds;
          if (snoop_wb) c_state <= C_WB;
          else begin
            cbus_ack_o <= 1'b1;
            c_state    <= C_ACK;
          end
        end
        C_WB: if (ack_c) begin
          cbus_ack_o <= 1'b1;
          c_state    <= C_ACK;
        end
        C_ACK:      c_state <= C_WAIT_NOP;
        C_WAIT_NOP: if (cb_idle) c_state <= C_IDLE;
        default:    c_state <= C_IDLE;
      endcase
    end
  end

  // A command on the bus runs to its ack; otherwise snoop write-back beats request traffic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mbus_cmd_o  <= MB_NOP;
      mbus_addr_o <= '0;
      c_owns      <= 1'b0;
    end else if (mb_busy) begin
      if (mbus_ack_i) begin
        mbus_cmd_o  <= MB_NOP;
        mbus_addr_o <= '0;
      end
    end else if (c_state == C_WB) begin
      mbus_cmd_o  <= MB_WR;
      mbus_addr_o <= c_addr;
      c_owns      <= 1'b1;
    end else if (r_state == R_WB) begin
      mbus_cmd_o  <= MB_WR;
      mbus_addr_o <= v_addr;
      c_owns      <= 1'b0;
    end else if (r_state == R_BROAD) begin
      mbus_cmd_o  <= r_wr ? MB_WRB : MB_RDB;
      mbus_addr_o <= r_addr;
      c_owns      <= 1'b0;
    end
  end

`ifdef MESI_ISC_AGENT_CNT_EN
  logic snoop_ack;
  assign snoop_ack = (c_decode && (is_wrs || is_rds) && !snoop_wb) || ((c_state == C_WB) && ack_c);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
      snoop_cnt_o <= '0;
    end else begin
      if (accept && ra_hit)  hit_cnt_o  <= sat_inc(hit_cnt_o);
      if (accept && !ra_hit) miss_cnt_o <= sat_inc(miss_cnt_o);
      if (snoop_ack)         snoop_cnt_o <= sat_inc(snoop_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_mesi_isc_cpu_agent.sv
// Directed cycle-by-cycle vectors for the MESI CPU agent plus reset-recovery sequence.
module tb_mesi_isc_cpu_agent;

  localparam logic [2:0] M_NOP = 3'd0, M_WR = 3'd1, M_WRB = 3'd3, M_RDB = 3'd4;
  localparam logic [2:0] C_NOP = 3'd0, C_WRS = 3'd1, C_RDS = 3'd2, C_ENW = 3'd3, C_ENR = 3'd4;
  localparam logic [31:0] A = 32'h100, B = 32'h104, C = 32'h200, D = 32'h300, Z = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_wr_i = 1'b0, mbus_ack_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cbus_addr_i = '0;
  logic [2:0]  cbus_cmd_i = '0;
  logic        cpu_busy_o, cpu_done_o, cbus_ack_o;
  logic [2:0]  mbus_cmd_o;
  logic [31:0] mbus_addr_o;

  int checks = 0;
  int errors = 0;

  mesi_isc_cpu_agent dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req_i  (cpu_req_i),
    .cpu_wr_i   (cpu_wr_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_busy_o (cpu_busy_o),
    .cpu_done_o (cpu_done_o),
    .mbus_cmd_o (mbus_cmd_o),
    .mbus_addr_o(mbus_addr_o),
    .mbus_ack_i (mbus_ack_i),
    .cbus_cmd_i (cbus_cmd_i),
    .cbus_addr_i(cbus_addr_i),
    .cbus_ack_o (cbus_ack_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          req, wr;
    logic [31:0] addr;
    logic [2:0]  cc;
    logic [31:0] ca;
    bit          ack;
    bit          busy, done;
    logic [2:0]  mcmd;
    logic [31:0] maddr;
    bit          cack;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit req, bit wr, logic [31:0] addr, logic [2:0] cc, logic [31:0] ca,
                              bit ack, bit busy, bit done, logic [2:0] mcmd, logic [31:0] maddr,
                              bit cack);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = addr; v.cc = cc; v.ca = ca; v.ack = ack;
    v.busy = busy; v.done = done; v.mcmd = mcmd; v.maddr = maddr; v.cack = cack;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit req, input bit wr, input logic [31:0] addr,
                       input logic [2:0] cc, input logic [31:0] ca, input bit ack);
    @(negedge clk);
    cpu_req_i = req; cpu_wr_i = wr; cpu_addr_i = addr;
    cbus_cmd_i = cc; cbus_addr_i = ca; mbus_ack_i = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input bit busy, input bit done, input logic [2:0] mcmd,
                         input logic [31:0] maddr, input bit cack);
    chk({tag, " busy"},  32'(cpu_busy_o),  32'(busy));
    chk({tag, " done"},  32'(cpu_done_o),  32'(done));
    chk({tag, " mcmd"},  32'(mbus_cmd_o),  32'(mcmd));
    chk({tag, " maddr"}, mbus_addr_o,      maddr);
    chk({tag, " cack"},  32'(cbus_ack_o),  32'(cack));
  endtask

  initial begin
    bit found;
    // read miss 0x100 -> RD_BROAD held, EN_RD fills S
    vq.push_back(mk(1,0,A, C_NOP,Z,0, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 1,0,M_RDB,A,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 1,0,M_RDB,A,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,1, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_ENR,A,0, 1,1,M_NOP,Z,1));
    vq.push_back(mk(0,0,Z, C_ENR,A,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_ENR,A,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    // read hit S; write to S -> WR_BROAD, EN_WR -> M; write hit M
    vq.push_back(mk(1,0,A, C_NOP,Z,0, 0,1,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(1,1,A, C_NOP,Z,0, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 1,0,M_WRB,A,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,1, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_ENW,A,0, 1,1,M_NOP,Z,1));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(1,1,A, C_NOP,Z,0, 0,1,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    // RD_SNOOP on M -> mbus WR then ack, line S; WR_SNOOP on S -> ack, line I
    vq.push_back(mk(0,0,Z, C_RDS,A,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_RDS,A,0, 0,0,M_WR,A,0));
    vq.push_back(mk(0,0,Z, C_RDS,A,1, 0,0,M_NOP,Z,1));
    vq.push_back(mk(0,0,Z, C_RDS,A,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(1,0,A, C_NOP,Z,0, 0,1,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_WRS,A,0, 0,0,M_NOP,Z,1));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    // write miss 0x100 -> M again
    vq.push_back(mk(1,1,A, C_NOP,Z,0, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 1,0,M_WRB,A,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,1, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_ENW,A,0, 1,1,M_NOP,Z,1));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    // read miss 0x104 with M victim 0x100 -> WR 0x100, then RD_BROAD 0x104
    vq.push_back(mk(1,0,B, C_NOP,Z,0, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 1,0,M_WR,A,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,1, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 1,0,M_RDB,B,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,1, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_ENR,B,0, 1,1,M_NOP,Z,1));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    // write 0x200, S victim -> no WR; WR_SNOOP 0x200 while waiting; EN_WR -> M
    vq.push_back(mk(1,1,C, C_NOP,Z,0, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 1,0,M_WRB,C,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,1, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_WRS,C,0, 1,0,M_NOP,Z,1));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 1,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_ENW,C,0, 1,1,M_NOP,Z,1));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(1,1,C, C_NOP,Z,0, 0,1,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    // request stalled behind a snoop until the cbus side is idle again
    vq.push_back(mk(1,0,C, C_RDS,D,0, 1,0,M_NOP,Z,1));
    vq.push_back(mk(1,0,C, C_NOP,Z,0, 1,0,M_NOP,Z,0));
    vq.push_back(mk(1,0,C, C_NOP,Z,0, 0,0,M_NOP,Z,0));
    vq.push_back(mk(1,0,C, C_NOP,Z,0, 0,1,M_NOP,Z,0));
    vq.push_back(mk(0,0,Z, C_NOP,Z,0, 0,0,M_NOP,Z,0));

    // reset state
    tick();
    tick();
    chk_all("reset", 0, 0, M_NOP, Z, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].req, vq[i].wr, vq[i].addr, vq[i].cc, vq[i].ca, vq[i].ack);
      tick();
      chk_all($sformatf("s%0d", i + 1), vq[i].busy, vq[i].done, vq[i].mcmd, vq[i].maddr, vq[i].cack);
    end

    // reset in R_WAIT_EN abandons the request and clears all lines
    drive(1, 0, 32'h101, C_NOP, Z, 0);
    tick();
    chk("rst_seq accept busy", 32'(cpu_busy_o), 32'd1);
    drive(0, 0, Z, C_NOP, Z, 0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (mbus_cmd_o == M_RDB && mbus_addr_o == 32'h101) found = 1'b1;
    end
    chk("rst_seq wait RD_BROAD 0x101", 32'(found), 32'd1);
    drive(0, 0, Z, C_NOP, Z, 1);
    tick();
    drive(0, 0, Z, C_NOP, Z, 0);
    tick();
    chk("rst_seq wait_en busy", 32'(cpu_busy_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_all("rst_mid", 0, 0, M_NOP, Z, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, Z, C_ENR, 32'h101, 0);
    tick();
    chk("rst_seq stale EN ack", 32'(cbus_ack_o), 32'd1);
    chk("rst_seq stale EN done", 32'(cpu_done_o), 32'd0);
    drive(0, 0, Z, C_NOP, Z, 0);
    tick();
    tick();
    tick();
    drive(1, 0, C, C_NOP, Z, 0);
    tick();
    chk("rst_seq 0x200 miss busy", 32'(cpu_busy_o), 32'd1);
    chk("rst_seq 0x200 miss done", 32'(cpu_done_o), 32'd0);
    drive(0, 0, Z, C_NOP, Z, 0);
    tick();
    chk("rst_seq 0x200 mcmd", 32'(mbus_cmd_o), 32'(M_RDB));
    chk("rst_seq 0x200 maddr", mbus_addr_o, C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
